// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and constants for the SPI frame master
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    localparam int ERR_DOUBLE_START_BP = 0;
    localparam int ERR_SMALL_PRESC_BP  = 1;

    localparam logic CPOL_IDLE_LOW  = 1'b0;
    localparam logic CPOL_IDLE_HIGH = 1'b1;
    localparam logic CPHA_LEADING   = 1'b0;
    localparam logic CPHA_TRAILING  = 1'b1;
    localparam logic DIR_MSB_FIRST  = 1'b0;
    localparam logic DIR_LSB_FIRST  = 1'b1;

endpackage

// File: rtl/spi_half_tick.sv
// rtl/spi_half_tick.sv - one-cycle tick every half_i cycles while enabled
module spi_half_tick #(
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] half_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == (half_i - PRESC_W'(1)));

    // Disabling reloads the counter so every frame starts with a full first interval.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - SPI frame master; SPI_FRAME_MASTER_ERR_EN enables err_o reporting
import spi_pkg::*;

module spi_frame_master #(
    parameter int DATA_W  = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start,
    input  logic [DATA_W-1:0]  tx_dat,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic               conf_cpol,
    input  logic               conf_cpha,
    input  logic               conf_dir,
    output logic               busy,
    output logic [DATA_W-1:0]  rx_dat,
    output logic               rx_valid,
    output logic [1:0]         err_o,
    output logic               sck,
    output logic               mosi,
    output logic               cs,
    input  logic               miso
);

    localparam int EDGES  = 2 * DATA_W;
    localparam int ECNT_W = $clog2(EDGES + 1);

    spi_state_e         state_q;
    logic [DATA_W-1:0]  tx_q;
    logic [PRESC_W-1:0] presc_q;
    logic               cpha_q;
    logic               dir_q;
    logic [ECNT_W-1:0]  ecnt_q;
    logic [DATA_W-1:0]  rxsh_q;
    logic [DATA_W-1:0]  rx_dat_q;
    logic               rx_valid_q;
    logic               busy_q;
    logic               cs_q;
    logic               sck_q;
    logic               mosi_q;
    logic               tick;

    spi_half_tick #(.PRESC_W(PRESC_W)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (state_q != ST_IDLE),
        .half_i (presc_q),
        .tick_o (tick)
    );

    // tx_ord/rxsh_q are kept in wire order: index k is the k-th bit on the line.
    logic [DATA_W-1:0] tx_ord;
    logic [DATA_W-1:0] tx_sel;
    logic [DATA_W-1:0] rx_mask;
    logic [DATA_W-1:0] rx_final;
    logic [ECNT_W-1:0] tx_idx;
    logic [ECNT_W-1:0] rx_idx;
    logic              leading;
    logic              last_edge;
    logic              do_edge;
    logic              do_sample;
    logic              do_drive;
    logic              next_bit;
    logic              first_bit;
    logic              accept;

    always_comb begin
        tx_ord    = dir_q ? tx_q : {<<{tx_q}};
        leading   = ~ecnt_q[0];
        last_edge = (ecnt_q == ECNT_W'(EDGES - 1));
        tx_idx    = cpha_q ? (ecnt_q >> 1) : (ECNT_W'(ecnt_q + ECNT_W'(1)) >> 1);
        rx_idx    = ecnt_q >> 1;
        tx_sel    = {{(DATA_W-1){1'b0}}, 1'b1} << tx_idx;
        next_bit  = |(tx_ord & tx_sel);
        rx_mask   = {{(DATA_W-1){1'b0}}, miso} << rx_idx;
        rx_final  = dir_q ? rxsh_q : {<<{rxsh_q}};
        do_edge   = tick && ((state_q == ST_LEAD) ||
                             ((state_q == ST_SHIFT) && (ecnt_q != ECNT_W'(EDGES))));
        do_sample = leading ^ cpha_q;
        do_drive  = cpha_q ? leading : (!leading && !last_edge);
        first_bit = conf_dir ? tx_dat[0] : tx_dat[DATA_W-1];
        accept    = start && (state_q == ST_IDLE) && (prescaler >= PRESC_W'(2));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            presc_q    <= PRESC_W'(2);
            cpha_q     <= 1'b0;
            dir_q      <= 1'b0;
            ecnt_q     <= '0;
            rxsh_q     <= '0;
            rx_dat_q   <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            cs_q       <= 1'b1;
            sck_q      <= conf_cpol;
            mosi_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_LEAD;
                        tx_q    <= tx_dat;
                        presc_q <= prescaler;
                        cpha_q  <= conf_cpha;
                        dir_q   <= conf_dir;
                        sck_q   <= conf_cpol;
                        ecnt_q  <= '0;
                        rxsh_q  <= '0;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b0;
                        mosi_q  <= first_bit;
                    end
                end
                ST_LEAD: begin
                    if (tick) state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick && (ecnt_q == ECNT_W'(EDGES))) state_q <= ST_TRAIL;
                end
                ST_TRAIL: begin
                    if (tick) begin
                        state_q    <= ST_GAP;
                        cs_q       <= 1'b1;
                        rx_dat_q   <= rx_final;
                        rx_valid_q <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (do_edge) begin
                sck_q  <= ~sck_q;
                ecnt_q <= ecnt_q + ECNT_W'(1);
                if (do_sample) rxsh_q <= rxsh_q | rx_mask;
                if (do_drive)  mosi_q <= next_bit;
            end
        end
    end

`ifdef SPI_FRAME_MASTER_ERR_EN
    logic [1:0] err_q;

    // A start in the GAP tick cycle still sees state_q != IDLE, so it counts as a double start.
    always_ff @(posedge clk_i) begin
        if (rst_i || accept) begin
            err_q <= '0;
        end else if (start) begin
            if (state_q != ST_IDLE) err_q[ERR_DOUBLE_START_BP] <= 1'b1;
            else                    err_q[ERR_SMALL_PRESC_BP]  <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 2'b00;
`endif

    assign busy     = busy_q;
    assign rx_dat   = rx_dat_q;
    assign rx_valid = rx_valid_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs       = cs_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - directed vector bench for spi_frame_master
module tb_spi_frame_master;

`ifdef SPI_FRAME_MASTER_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start;
    logic [15:0] tx_dat;
    logic [7:0]  prescaler;
    logic        conf_cpol, conf_cpha, conf_dir;
    logic        busy, rx_valid, sck, mosi, cs, miso;
    logic [15:0] rx_dat;
    logic [1:0]  err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    spi_frame_master #(.DATA_W(16), .PRESC_W(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (start),
        .tx_dat    (tx_dat),
        .prescaler (prescaler),
        .conf_cpol (conf_cpol),
        .conf_cpha (conf_cpha),
        .conf_dir  (conf_dir),
        .busy      (busy),
        .rx_dat    (rx_dat),
        .rx_valid  (rx_valid),
        .err_o     (err_o),
        .sck       (sck),
        .mosi      (mosi),
        .cs        (cs),
        .miso      (miso)
    );

    // Mode-0 16-bit slave model returning 0x1234 and capturing the master's word.
    logic        use_slave = 1'b0;
    logic [15:0] slv_out = 16'h0;
    logic [15:0] slv_in = 16'h0;
    logic [15:0] slv_dat = 16'h0;
    int          slv_wr = 0;

    assign miso = use_slave ? slv_out[15] : mosi;

    always @(negedge cs) slv_out = 16'h1234;
    always @(posedge sck) if (!cs) slv_in = {slv_in[14:0], mosi};
    always @(negedge sck) if (!cs) slv_out = slv_out << 1;
    always @(posedge cs) begin
        slv_dat = slv_in;
        slv_wr++;
    end

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic        dir;
        logic [7:0]  h;
        logic [15:0] tx;
        logic        slave;
        int          inject;
        logic [15:0] exp_rx;
        logic        exp_first;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          cyc, bc, edges, nv, wr0;
        logic        prev, first, got;
        logic [15:0] rxv;
        wr0       = slv_wr;
        use_slave = v.slave;
        @(negedge clk_i);
        conf_cpol = v.cpol;
        conf_cpha = v.cpha;
        conf_dir  = v.dir;
        tx_dat    = v.tx;
        prescaler = v.h;
        start     = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
        cyc = 0; bc = 0; edges = 0; nv = 0; got = 1'b0; first = 1'b0;
        rxv = 16'h0; prev = sck;
        while (busy && cyc < 2000) begin
            bc++;
            if (sck !== prev) edges++;
            prev = sck;
            if (!got && (v.cpha == 1'b0 || edges == 1)) begin
                first = mosi;
                got   = 1'b1;
            end
            if (rx_valid) begin
                nv++;
                rxv = rx_dat;
            end
            if (cyc == v.inject) begin
                start     = 1'b1;
                tx_dat    = ~v.tx;
                prescaler = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        start = 1'b0;
        chk($sformatf("v%0d timeout", id), 32'(cyc < 2000), 32'd1);
        repeat (4) begin
            if (rx_valid) nv++;
            @(negedge clk_i);
        end
        chk($sformatf("v%0d busy_cycles", id), 32'(bc), 32'(35 * int'(v.h)));
        chk($sformatf("v%0d sck_edges", id), 32'(edges), 32'd32);
        chk($sformatf("v%0d rx_valid_count", id), 32'(nv), 32'd1);
        chk($sformatf("v%0d rx_at_valid", id), 32'(rxv), 32'(v.exp_rx));
        chk($sformatf("v%0d rx_dat", id), 32'(rx_dat), 32'(v.exp_rx));
        chk($sformatf("v%0d first_mosi", id), 32'(first), 32'(v.exp_first));
        chk($sformatf("v%0d err", id), 32'(err_o), 32'(v.exp_err));
        chk($sformatf("v%0d sck_idle", id), 32'(sck), 32'(v.cpol));
        chk($sformatf("v%0d cs_idle", id), 32'(cs), 32'd1);
        if (v.slave) begin
            chk($sformatf("v%0d slave_dat", id), 32'(slv_dat), 32'(v.tx));
            chk($sformatf("v%0d slave_wr_req", id), 32'(slv_wr - wr0), 32'd1);
        end
    endtask

    initial begin
        int   edges, nv;
        logic prev;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd4, 16'hA5C3, 1'b0, -1, 16'hA5C3, 1'b1, 2'b00};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'd4, 16'hBEEF, 1'b1, -1, 16'h1234, 1'b1, 2'b00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8'd2, 16'h0001, 1'b0, -1, 16'h0001, 1'b1, 2'b00};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'd4, 16'h5A3C, 1'b0, 20, 16'h5A3C, 1'b0, {1'b0, ERR_EN}};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'd3, 16'h8001, 1'b0, -1, 16'h8001, 1'b1, 2'b00};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'd5, 16'h6C00, 1'b0, -1, 16'h6C00, 1'b0, 2'b00};

        rst_i = 1'b1; start = 1'b0; tx_dat = 16'h0; prescaler = 8'd4;
        conf_cpol = 1'b0; conf_cpha = 1'b0; conf_dir = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset cs", 32'(cs), 32'd1);
        chk("reset sck", 32'(sck), 32'd0);
        chk("reset mosi", 32'(mosi), 32'd0);
        chk("reset rx_dat", 32'(rx_dat), 32'd0);
        chk("reset rx_valid", 32'(rx_valid), 32'd0);
        chk("reset err", 32'(err_o), 32'd0);

        prescaler = 8'd1;
        start     = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
        chk("presc1 busy", 32'(busy), 32'd0);
        chk("presc1 err", 32'(err_o), 32'({ERR_EN, 1'b0}));
        repeat (3) @(negedge clk_i);
        chk("presc1 busy_later", 32'(busy), 32'd0);
        chk("presc1 cs", 32'(cs), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        use_slave = 1'b0;
        conf_cpol = 1'b0; conf_cpha = 1'b0; conf_dir = 1'b0;
        tx_dat = 16'h1357; prescaler = 8'd4; start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
        edges = 0; nv = 0; prev = sck;
        for (int c = 0; c < 1000 && edges < 10; c++) begin
            @(negedge clk_i);
            if (sck !== prev) edges++;
            prev = sck;
            if (rx_valid) nv++;
        end
        chk("abort reached_edge10", 32'(edges), 32'd10);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("abort cs", 32'(cs), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort sck", 32'(sck), 32'd0);
        chk("abort mosi", 32'(mosi), 32'd0);
        repeat (200) begin
            if (rx_valid) nv++;
            @(negedge clk_i);
        end
        chk("abort rx_valid_count", 32'(nv), 32'd0);
        chk("abort rx_dat", 32'(rx_dat), 32'd0);

        run_vec(vecs[0], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_master.md
SPI_FRAME_MASTER -- requirements
Module: spi_frame_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, frame length in bits.
REQ-002 SHALL have parameter PRESC_W, default 8, width of the prescaler input.
REQ-003 SHALL have port clk_i  in  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  single-cycle frame request.
REQ-006 SHALL have port tx_dat  in  DATA_W  frame to transmit.
REQ-007 SHALL have port prescaler  in  PRESC_W  SCK half-period H, in clk_i cycles.
REQ-008 SHALL have ports conf_cpol, conf_cpha, conf_dir  in  1 each: idle SCK level, phase (0 = sample on leading edge), bit order (0 = MSB first).
REQ-009 SHALL have port busy  out  1  frame in progress.
REQ-010 SHALL have port rx_dat  out  DATA_W  last received frame.
REQ-011 SHALL have port rx_valid  out  1  one-cycle pulse when rx_dat updates.
REQ-012 SHALL have port err_o  out  2  sticky errors: bit0 = start while busy, bit1 = prescaler < 2.
REQ-013 SHALL have ports sck, mosi, cs  out  1 each, and miso  in  1: SPI pins to the slave's phy interface.

Function
REQ-014 Start acceptance: start SHALL be accepted only in IDLE with prescaler >= 2.
- On acceptance, tx_dat, prescaler, conf_* SHALL be latched.
- Input changes mid-frame SHALL be ignored.
REQ-015 States SHALL be IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE.
- busy SHALL rise the cycle after acceptance and stay high exactly 35*H cycles.
REQ-016 CS SHALL be low from LEAD entry through TRAIL end and high in IDLE and GAP.
- LEAD, TRAIL and GAP SHALL each last H cycles.
REQ-017 SHIFT SHALL produce 2*DATA_W SCK edges spaced H cycles apart; SCK SHALL equal latched cpol outside SHIFT.
REQ-018 MOSI bit order SHALL be bit DATA_W-1 down to 0 when conf_dir = 0, else bit 0 up to DATA_W-1.
REQ-019 cpha = 0 timing:
- First bit SHALL be on MOSI at LEAD entry.
- MISO SHALL be sampled on each leading edge.
- MOSI SHALL advance on each trailing edge except the last.
REQ-020 cpha = 1 timing:
- MOSI SHALL advance on each leading edge.
- MISO SHALL be sampled on each trailing edge.
REQ-021 Received bits SHALL be assembled in the same order as conf_dir.
- rx_dat SHALL update, and rx_valid SHALL pulse, in the first GAP cycle.
REQ-022 A start while busy SHALL be ignored and SHALL set err_o[0]; the running frame SHALL be unaffected.
REQ-023 A start in IDLE with prescaler < 2 SHALL be rejected and SHALL set err_o[1].
REQ-024 Both error bits SHALL stay set until rst_i or the next accepted start clears them.
REQ-025 A start in the same cycle busy falls SHALL be treated as a start while busy.

Reset
REQ-026 rst_i SHALL force the following, including mid-frame; an aborted frame SHALL produce no rx_valid:
- IDLE state.
- busy = 0, cs = 1, sck = conf_cpol, mosi = 0.
- rx_dat = 0, rx_valid = 0, err_o = 0.

Configuration
REQ-027 Macro SPI_FRAME_MASTER_ERR_EN SHALL control error reporting.
- Defined: err_o SHALL behave as REQ-022..REQ-024.
- Undefined: err_o SHALL be constant 0; invalid starts SHALL still be ignored.

Structure
REQ-028 Package spi_pkg SHALL hold:
- State enum.
- Error bit positions (ERR_DOUBLE_START_BP = 0, ERR_SMALL_PRESC_BP = 1).
- CPOL/CPHA/bit-order constants.
REQ-029 Sub-module spi_half_tick SHALL generate a one-cycle tick every H cycles while enabled and reload on disable; the FSM SHALL advance only on its ticks.

Verification
REQ-030 Bench SHALL cover the following scenarios:
- Mode 0, MSB first, H = 4, tx 0xA5C3, miso looped to mosi -> 32 SCK edges, busy 140 cycles, rx_dat 0xA5C3, one rx_valid.
- Mode 0 into spi_16bit_slave (dat_o 0x1234), tx 0xBEEF -> slave dat_i 0xBEEF with wr_req, master rx_dat 0x1234.
- Mode 3, LSB first, H = 2, tx 0x0001 -> first MOSI bit 1, sck idles high, loopback rx 0x0001.
- Start with prescaler 1 -> busy stays 0, err_o = 2'b10; next valid start clears err_o.
- Second start mid-frame -> err_o[0] = 1, frame completes unchanged, single rx_valid.
- rst_i at edge 10 -> next cycle cs = 1, busy = 0, no rx_valid; following frame correct.
